// File: rtl/salsa_pkg.sv
// Shared types and constants for the Salsa20 xor-stream front end.
// Holds the FSM state enum, block geometry and the input word mux.
package salsa_pkg;

    localparam int SALSA_IN_WORDS    = 12;
    localparam int SALSA_BLOCK_BYTES = 64;
    localparam int WORD_CNT_W        = 4;
    localparam int BYTE_IDX_W        = 6;

    typedef logic [WORD_CNT_W-1:0] word_cnt_t;
    typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_FILL,
        ST_XOR
    } state_e;

    localparam word_cnt_t LAST_WORD = word_cnt_t'(SALSA_IN_WORDS - 1);
    localparam byte_idx_t LAST_BYTE = byte_idx_t'(SALSA_BLOCK_BYTES - 1);

    // Serial word n of the core input: key0..7, nonce0..1, pos lo, pos hi.
    function automatic logic [31:0] in_word(
        input logic [255:0] key,
        input logic [63:0]  nonce,
        input logic [63:0]  pos,
        input word_cnt_t    n
    );
        logic [31:0] w;
        w = '0;
        case (n)
            4'd8:    w = nonce[31:0];
            4'd9:    w = nonce[63:32];
            4'd10:   w = pos[31:0];
            4'd11:   w = pos[63:32];
            default: w = key[{n[2:0], 5'd0} +: 32];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/salsa_ks_buffer.sv
// 64x8 keystream buffer: one write port, one combinational read port.
// Ports: clk, reset_n, we/waddr/wdata (write), raddr/rdata (read).
module salsa_ks_buffer
    import salsa_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic [5:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [SALSA_BLOCK_BYTES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SALSA_BLOCK_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/salsa_xor_stream.sv
// Salsa20 byte-stream engine around salsa_hash: sends key/nonce/pos words,
// buffers 64 keystream bytes, XORs them onto the plaintext stream.
// Ports: cfg_* (key/nonce/pos load), halt, pt_*/ct_* byte streams,
// hash_* (core word in / byte out), pos_out (current block), busy.
module salsa_xor_stream
    import salsa_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [255:0] cfg_key,
    input  logic [63:0]  cfg_nonce,
    input  logic [63:0]  cfg_pos,
    input  logic         halt,
    input  logic         pt_valid,
    output logic         pt_ready,
    input  logic [7:0]   pt_data,
    output logic         ct_valid,
    input  logic         ct_ready,
    output logic [7:0]   ct_data,
    output logic         hash_start,
    output logic [31:0]  hash_data,
    input  logic         hash_ready,
    input  logic         hash_writes,
    input  logic [7:0]   hash_byte,
    output logic [63:0]  pos_out,
    output logic         busy
);

    state_e       state_q;
    state_e       state_d;
    word_cnt_t    word_cnt;
    byte_idx_t    idx;
    logic         halt_q;
    logic [255:0] key_q;
    logic [63:0]  nonce_q;
    logic [7:0]   ks_byte;

    logic cfg_fire;
    logic send_fire;
    logic ks_we;
    logic pt_fire;
    logic last_fill;
    logic last_xor;
    logic in_block;

    assign cfg_fire  = (state_q == ST_IDLE) && cfg_valid;
    // Word 0 waits for the core; the rest follow back to back.
    assign send_fire = (state_q == ST_SEND) &&
                       ((word_cnt != '0) || hash_ready);
    assign ks_we     = ((state_q == ST_WAIT) || (state_q == ST_FILL)) &&
                       hash_writes;
    assign pt_fire   = pt_valid && pt_ready;
    assign last_fill = (state_q == ST_FILL) && hash_writes &&
                       (idx == LAST_BYTE);
    assign last_xor  = pt_fire && (idx == LAST_BYTE);
    assign in_block  = (state_q == ST_SEND) || (state_q == ST_WAIT) ||
                       (state_q == ST_FILL);

    salsa_ks_buffer u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ks_we),
        .waddr   (idx),
        .wdata   (hash_byte),
        .raddr   (idx),
        .rdata   (ks_byte)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_valid) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (send_fire && (word_cnt == LAST_WORD)) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (hash_writes) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (last_fill) begin
                    state_d = (halt_q || halt) ? ST_IDLE : ST_XOR;
                end
            end
            ST_XOR: begin
                if (halt) begin
                    state_d = ST_IDLE;
                end else if (last_xor) begin
                    state_d = ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        pt_ready  = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_XOR: begin
                pt_ready = !ct_valid || ct_ready;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt   <= '0;
            idx        <= '0;
            halt_q     <= 1'b0;
            key_q      <= '0;
            nonce_q    <= '0;
            pos_out    <= '0;
            hash_start <= 1'b0;
            hash_data  <= '0;
        end else begin
            hash_start <= 1'b0;
            hash_data  <= '0;
            if (cfg_fire) begin
                key_q   <= cfg_key;
                nonce_q <= cfg_nonce;
                pos_out <= cfg_pos;
                halt_q  <= 1'b0;
                idx     <= '0;
                // Issue word 0 straight from the cfg bus when the core is idle.
                if (hash_ready) begin
                    hash_start <= 1'b1;
                    hash_data  <= cfg_key[31:0];
                    word_cnt   <= word_cnt_t'(1);
                end else begin
                    word_cnt <= '0;
                end
            end
            if (send_fire) begin
                hash_start <= (word_cnt == '0);
                hash_data  <= in_word(key_q, nonce_q, pos_out, word_cnt);
                word_cnt   <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
            end
            if (halt && in_block) halt_q <= 1'b1;
            if (last_fill) halt_q <= 1'b0;
            // idx wraps to 0 after byte 63 in both FILL and XOR.
            if (ks_we) idx <= idx + 1'b1;
            if (pt_fire) idx <= idx + 1'b1;
            if ((state_q == ST_XOR) && halt) idx <= '0;
            if (last_xor) pos_out <= pos_out + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ct_valid <= 1'b0;
            ct_data  <= '0;
        end else if (pt_fire) begin
            ct_valid <= 1'b1;
            ct_data  <= pt_data ^ ks_byte;
        end else if (ct_ready) begin
            ct_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_salsa_xor_stream.sv
// Directed bench for salsa_xor_stream with a behavioural salsa_hash stand-in.
// Drives cfg/pt streams, collects ct bytes and checks hand-computed values.
module tb_salsa_xor_stream;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [255:0] cfg_key = '0;
    logic [63:0]  cfg_nonce = '0;
    logic [63:0]  cfg_pos = '0;
    logic         halt = 1'b0;
    logic         pt_valid = 1'b0;
    logic         pt_ready;
    logic [7:0]   pt_data = 8'hFF;
    logic         ct_valid;
    logic         ct_ready = 1'b1;
    logic [7:0]   ct_data;
    logic         hash_start;
    logic [31:0]  hash_data;
    logic         hash_ready = 1'b1;
    logic         hash_writes = 1'b0;
    logic [7:0]   hash_byte = '0;
    logic [63:0]  pos_out;
    logic         busy;

    int n_chk = 0;
    int n_err = 0;

    int cap_n = 12;
    int dly = 0;
    int emit_i = 64;
    int blocks = 0;
    int start_extra = 0;
    logic [31:0] words [12];

    bit pt_en = 1'b0;
    int pt_limit = 0;
    int pt_sent = 0;
    int ct_mode = 0;
    int cyc = 0;
    int stall_bad = 0;
    logic [7:0] ct_q [$];
    int ct_cyc [$];

    salsa_xor_stream dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_key     (cfg_key),
        .cfg_nonce   (cfg_nonce),
        .cfg_pos     (cfg_pos),
        .halt        (halt),
        .pt_valid    (pt_valid),
        .pt_ready    (pt_ready),
        .pt_data     (pt_data),
        .ct_valid    (ct_valid),
        .ct_ready    (ct_ready),
        .ct_data     (ct_data),
        .hash_start  (hash_start),
        .hash_data   (hash_data),
        .hash_ready  (hash_ready),
        .hash_writes (hash_writes),
        .hash_byte   (hash_byte),
        .pos_out     (pos_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Core stand-in: capture 12 words, wait 30 cycles, emit bytes 0..63.
    always @(negedge clk) begin
        if (!reset_n) begin
            cap_n = 12;
            dly = 0;
            emit_i = 64;
            hash_writes = 1'b0;
        end else begin
            hash_writes = 1'b0;
            if (hash_start) begin
                if (cap_n < 12) start_extra++;
                words[0] = hash_data;
                cap_n = 1;
                blocks++;
            end else if (cap_n < 12) begin
                words[cap_n] = hash_data;
                cap_n++;
                if (cap_n == 12) dly = 30;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) emit_i = 0;
            end else if (emit_i < 64) begin
                hash_writes = 1'b1;
                hash_byte = emit_i[7:0];
                emit_i++;
            end
        end
    end

    // Byte streams: drive on negedge, sample 1 ns before the posedge.
    always @(negedge clk) begin
        cyc++;
        if (ct_mode == 0) ct_ready = 1'b1;
        else if (ct_mode == 1) ct_ready = ~ct_ready;
        else ct_ready = 1'b0;
        pt_valid = pt_en && (pt_sent < pt_limit);
        #4;
        if (ct_valid && ct_ready) begin
            ct_q.push_back(ct_data);
            ct_cyc.push_back(cyc);
        end
        if (ct_valid && !ct_ready && pt_ready) stall_bad++;
        if (pt_valid && pt_ready) pt_sent++;
    end

    task automatic do_cfg(input logic [255:0] k, input logic [63:0] n,
                          input logic [63:0] p);
        @(negedge clk);
        cfg_key = k;
        cfg_nonce = n;
        cfg_pos = p;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_block(input int n);
        logic ok;
        ok = 1'b0;
        repeat (200) begin
            @(negedge clk);
            #1;
            if (blocks >= n && cap_n == 12) begin
                ok = 1'b1;
                break;
            end
        end
        check("to_block", ok, 1'b1);
    endtask

    task automatic wait_ct(input int n);
        logic ok;
        ok = 1'b0;
        repeat (400) begin
            @(negedge clk);
            #1;
            if (ct_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check("to_ct", ok, 1'b1);
    endtask

    task automatic wait_emit(input int n);
        logic ok;
        ok = 1'b0;
        repeat (200) begin
            @(negedge clk);
            #1;
            if (emit_i == n) begin
                ok = 1'b1;
                break;
            end
        end
        check("to_emit", ok, 1'b1);
    endtask

    task automatic wait_pt(input int n);
        logic ok;
        ok = 1'b0;
        repeat (200) begin
            @(negedge clk);
            #1;
            if (pt_sent >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check("to_pt", ok, 1'b1);
    endtask

    task automatic clear_ct();
        ct_q.delete();
        ct_cyc.delete();
    endtask

    initial begin
        logic [255:0] k1;
        logic [31:0]  exp_w [12];
        int nb;
        int bad;

        for (int i = 0; i < 8; i++) begin
            k1[32*i +: 32] = 32'(i + 1);
        end
        for (int i = 0; i < 8; i++) exp_w[i] = 32'(i + 1);
        exp_w[8]  = 32'hA0;
        exp_w[9]  = 32'hA1;
        exp_w[10] = 32'h0000_0005;
        exp_w[11] = 32'h0000_0002;

        #2 reset_n = 1'b0;
        #1;
        check("rst_cfg_ready", cfg_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_hash_start", hash_start, 1'b0);
        check("rst_hash_data", hash_data, 32'h0);
        check("rst_pt_ready", pt_ready, 1'b0);
        check("rst_ct_valid", ct_valid, 1'b0);
        check("rst_ct_data", ct_data, 8'h00);
        check("rst_pos", pos_out, 64'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        nb = blocks + 1;
        do_cfg(k1, 64'h0000_00A1_0000_00A0, 64'h0000_0002_0000_0005);
        wait_block(nb);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("word%0d", i), words[i], exp_w[i]);
        end
        check("start_once", start_extra, 0);
        check("pos_load", pos_out, 64'h0000_0002_0000_0005);

        clear_ct();
        pt_en = 1'b1;
        pt_sent = 0;
        pt_limit = 64;
        ct_mode = 0;
        nb = blocks + 1;
        wait_ct(64);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (ct_q[i] !== (8'hFF ^ 8'(i))) bad++;
        end
        check("ct_run1_bytes", bad, 0);
        check("ct_run1_first", ct_q[0], 8'hFF);
        check("ct_run1_last", ct_q[63], 8'hC0);
        check("ct_run1_rate", ct_cyc[63] - ct_cyc[0], 63);
        check("pos_inc", pos_out, 64'h0000_0002_0000_0006);
        wait_block(nb);
        check("resend_w10", words[10], 32'h0000_0006);
        check("resend_w11", words[11], 32'h0000_0002);

        clear_ct();
        pt_sent = 0;
        stall_bad = 0;
        ct_mode = 1;
        nb = blocks + 1;
        wait_ct(64);
        repeat (4) @(negedge clk);
        #1;
        check("bp_count", ct_q.size(), 64);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (ct_q[i] !== (8'hFF ^ 8'(i))) bad++;
        end
        check("bp_bytes", bad, 0);
        check("bp_stall", stall_bad, 0);
        check("bp_pt_sent", pt_sent, 64);
        check("bp_pos", pos_out, 64'h0000_0002_0000_0007);

        ct_mode = 0;
        wait_block(nb);
        clear_ct();
        pt_sent = 0;
        wait_emit(20);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        wait_emit(64);
        check("hf_busy_fill", busy, 1'b1);
        @(negedge clk);
        #1;
        check("hf_idle", busy, 1'b0);
        check("hf_cfg_ready", cfg_ready, 1'b1);
        check("hf_pt_ready", pt_ready, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("hf_no_pt", pt_sent, 0);

        nb = blocks + 1;
        do_cfg(~k1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_block(nb);
        check("wrap_w10_pre", words[10], 32'hFFFF_FFFF);
        check("wrap_w11_pre", words[11], 32'hFFFF_FFFF);
        clear_ct();
        pt_sent = 0;
        nb = blocks + 1;
        wait_ct(64);
        check("wrap_pos", pos_out, 64'h0);
        check("wrap_ct5", ct_q[5], 8'hFA);
        wait_block(nb);
        check("wrap_w10", words[10], 32'h0);
        check("wrap_w11", words[11], 32'h0);

        clear_ct();
        pt_sent = 0;
        pt_limit = 11;
        wait_pt(10);
        ct_mode = 2;
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        #1;
        halt = 1'b0;
        check("hx_idle", busy, 1'b0);
        check("hx_cfg_ready", cfg_ready, 1'b1);
        check("hx_pt_ready", pt_ready, 1'b0);
        check("hx_ct_pending", ct_valid, 1'b1);
        check("hx_ct_data", ct_data, 8'hF5);
        ct_mode = 0;
        repeat (4) @(negedge clk);
        #1;
        check("hx_ct_count", ct_q.size(), 11);
        check("hx_ct_last", ct_q[ct_q.size()-1], 8'hF5);
        check("hx_ct_drained", ct_valid, 1'b0);

        pt_limit = 0;
        nb = blocks + 1;
        do_cfg(k1, 64'h0, 64'h0000_0000_0000_0030);
        wait_block(nb);
        #1;
        repeat (3) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("ar_cfg_ready", cfg_ready, 1'b1);
        check("ar_busy", busy, 1'b0);
        check("ar_hash_start", hash_start, 1'b0);
        check("ar_hash_data", hash_data, 32'h0);
        check("ar_pos", pos_out, 64'h0);
        check("ar_ct_valid", ct_valid, 1'b0);
        check("ar_pt_ready", pt_ready, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        nb = blocks + 1;
        do_cfg(k1, 64'h0000_00A1_0000_00A0, 64'h0000_0000_0000_0007);
        wait_block(nb);
        check("ar_w0", words[0], 32'h1);
        check("ar_w8", words[8], 32'hA0);
        check("ar_w10", words[10], 32'h7);
        check("ar_extra", start_extra, 0);
        clear_ct();
        pt_sent = 0;
        pt_limit = 64;
        wait_ct(64);
        check("ar_ct0", ct_q[0], 8'hFF);
        check("ar_ct63", ct_q[63], 8'hC0);
        check("ar_pos_inc", pos_out, 64'h8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
